axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI read-address/read-data port between icache and dcache.
- Round-robin arbitration on AR. Granted request is registered into an output slice and held until the bus accepts it.
- Source tag is forced into arid[0]: 0 = icache, 1 = dcache. R beats are steered back by rid[0].
- Per-requester outstanding-burst counters throttle each cache. A sticky error flags orphan responses.

Parameters:
ID_WIDTH, 13, AXI ID width
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width
MAX_OUTSTANDING, 4, max in-flight read bursts per requester (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
icache_m_axi_ar{id,addr,len,size,burst,lock,cache,prot}  input  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  icache AR payload
icache_m_axi_arvalid / icache_m_axi_arready  input/output  1/1  icache AR handshake
icache_m_axi_r{id,data,resp,last,valid}  output  ID_WIDTH/DATA_WIDTH/2/1/1  icache R channel
icache_m_axi_rready  input  1  icache R ready
dcache_m_axi_ar*, dcache_m_axi_r*  same as icache  same  dcache AR/R channels
m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  output  as above  bus AR, registered
m_axi_arready  input  1  bus AR ready
m_axi_r{id,data,resp,last,valid}  input  as above  bus R channel
m_axi_rready  output  1  bus R ready
rsp_err  output  1  sticky: R beat arrived for a requester with zero outstanding

Behaviour:
- Reset: state IDLE; m_axi_arvalid=0; all m_axi_ar* payload regs=0; both counters=0; rsp_err=0; rr pointer last_grant=dcache, so icache wins the first tie. Reset mid-operation drops any held AR and clears the counters.
- Eligibility: elig_x = x_arvalid && cnt_x < MAX_OUTSTANDING.
- FSM IDLE:
  - If neither requester is eligible, stay in IDLE.
  - If one is eligible, grant it. If both are eligible, grant the one that is not last_grant.
  - x_arready=1 combinationally, in the same cycle, only for the granted requester. All other arready=0, and always 0 outside IDLE.
  - On the grant handshake: capture the payload into the m_axi_ar* regs with arid[0] overwritten by the tag (arid[ID_WIDTH-1:1] passed through). Set m_axi_arvalid=1, update last_grant, increment cnt_x, go to BUSY.
- FSM BUSY:
  - Hold m_axi_ar* stable with m_axi_arvalid=1 until m_axi_arready.
  - On the accepting edge: m_axi_arvalid=0, go to IDLE.
  - Next grant is possible in the following cycle, so throughput is at most one AR per 2 cycles.
  - Latency: requester handshake at cycle N -> m_axi_arvalid high at N+1.
- R routing (combinational, no storage):
  - rid[0]=0 -> icache_rvalid=m_axi_rvalid, dcache_rvalid=0, m_axi_rready=icache_rready.
  - rid[0]=1 -> the mirror case.
  - rid/rdata/rresp/rlast are broadcast to both requesters unmodified.
- Counters: width $clog2(MAX_OUTSTANDING+1).
  - cnt_x increments on the x AR handshake.
  - cnt_x decrements on an R handshake with rlast for target x.
  - Increment and decrement in the same cycle leave the count unchanged.
  - The counter never exceeds MAX_OUTSTANDING, since eligibility blocks further grants.
- Orphan response: an R handshake with rlast to a target whose cnt is 0 sets rsp_err (sticky until reset). The counter holds at 0 (no underflow) and the beat is still routed.
- Non-last R beats do not touch the counters.

Test Plan:
1. Single request: icache arvalid, araddr=0x1000, arid=0x2 at cycle 0 -> icache_arready=1 at cycle 0. m_axi_arvalid=1 at cycle 1 with araddr=0x1000, arid=0x2. m_axi_arready held low 3 cycles -> payload stable throughout, arvalid drops after acceptance; cnt_i=1.
2. Tie after reset: both caches valid, dcache arid=0x4 -> icache granted first (arid[0]=0). Second grant goes to dcache, m_axi_arid=0x5. Third alternates back to icache.
3. Throttle: MAX_OUTSTANDING=4, icache issues 4 ARs with no R returned -> 5th icache arvalid gets arready=0 indefinitely while a dcache request is still granted. One R beat with rlast and rid[0]=0 -> icache granted again.
4. R steering: 4-beat burst rid=0x3 with dcache_rready toggling 1,0,1 -> icache_rvalid always 0. m_axi_rready mirrors dcache_rready. cnt_d decrements only on the rlast handshake.
5. Simultaneous: icache AR handshake in the same cycle as an icache rlast handshake with cnt_i=2 -> cnt_i stays 2.
6. Orphan and reset: R rlast with rid[0]=1 while cnt_d=0 -> rsp_err=1 and stays set; assert reset while in BUSY -> next cycle m_axi_arvalid=0, counters=0, rsp_err=0.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Two-way AXI read arbiter: round-robin AR grant into a registered slice, R beats steered by
// rid[0], per-requester outstanding-burst throttling and a sticky orphan-response flag.
module axi_read_arbiter #(
   parameter int unsigned ID_WIDTH        = 13,
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   // icache
   input  logic [ID_WIDTH-1:0]   icache_m_axi_arid_i,
   input  logic [ADDR_WIDTH-1:0] icache_m_axi_araddr_i,
   input  logic [7:0]            icache_m_axi_arlen_i,
   input  logic [2:0]            icache_m_axi_arsize_i,
   input  logic [1:0]            icache_m_axi_arburst_i,
   input  logic                  icache_m_axi_arlock_i,
   input  logic [3:0]            icache_m_axi_arcache_i,
   input  logic [2:0]            icache_m_axi_arprot_i,
   input  logic                  icache_m_axi_arvalid_i,
   output logic                  icache_m_axi_arready_o,
   output logic [ID_WIDTH-1:0]   icache_m_axi_rid_o,
   output logic [DATA_WIDTH-1:0] icache_m_axi_rdata_o,
   output logic [1:0]            icache_m_axi_rresp_o,
   output logic                  icache_m_axi_rlast_o,
   output logic                  icache_m_axi_rvalid_o,
   input  logic                  icache_m_axi_rready_i,
   // dcache
   input  logic [ID_WIDTH-1:0]   dcache_m_axi_arid_i,
   input  logic [ADDR_WIDTH-1:0] dcache_m_axi_araddr_i,
   input  logic [7:0]            dcache_m_axi_arlen_i,
   input  logic [2:0]            dcache_m_axi_arsize_i,
   input  logic [1:0]            dcache_m_axi_arburst_i,
   input  logic                  dcache_m_axi_arlock_i,
   input  logic [3:0]            dcache_m_axi_arcache_i,
   input  logic [2:0]            dcache_m_axi_arprot_i,
   input  logic                  dcache_m_axi_arvalid_i,
   output logic                  dcache_m_axi_arready_o,
   output logic [ID_WIDTH-1:0]   dcache_m_axi_rid_o,
   output logic [DATA_WIDTH-1:0] dcache_m_axi_rdata_o,
   output logic [1:0]            dcache_m_axi_rresp_o,
   output logic                  dcache_m_axi_rlast_o,
   output logic                  dcache_m_axi_rvalid_o,
   input  logic                  dcache_m_axi_rready_i,
   // shared bus
   output logic [ID_WIDTH-1:0]   m_axi_arid_o,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
   output logic [7:0]            m_axi_arlen_o,
   output logic [2:0]            m_axi_arsize_o,
   output logic [1:0]            m_axi_arburst_o,
   output logic                  m_axi_arlock_o,
   output logic [3:0]            m_axi_arcache_o,
   output logic [2:0]            m_axi_arprot_o,
   output logic                  m_axi_arvalid_o,
   input  logic                  m_axi_arready_i,
   input  logic [ID_WIDTH-1:0]   m_axi_rid_i,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
   input  logic [1:0]            m_axi_rresp_i,
   input  logic                  m_axi_rlast_i,
   input  logic                  m_axi_rvalid_i,
   output logic                  m_axi_rready_o,
   output logic                  rsp_err_o
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;  // 1 = dcache
   logic [CntW-1:0]       cnt_i_q, cnt_i_d;
   logic [CntW-1:0]       cnt_d_q, cnt_d_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic [7:0]            ar_len_q, ar_len_d;
   logic [2:0]            ar_size_q, ar_size_d;
   logic [1:0]            ar_burst_q, ar_burst_d;
   logic                  ar_lock_q, ar_lock_d;
   logic [3:0]            ar_cache_q, ar_cache_d;
   logic [2:0]            ar_prot_q, ar_prot_d;
   logic                  ar_valid_q, ar_valid_d;

   logic elig_i, elig_d;
   logic gnt_i, gnt_d;
   logic r_tgt_d, r_last_hs, rlast_i, rlast_d, dec_i, dec_d;

   assign elig_i = icache_m_axi_arvalid_i && (cnt_i_q < MaxCnt);
   assign elig_d = dcache_m_axi_arvalid_i && (cnt_d_q < MaxCnt);

   // Arbitration and AR output slice
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_i        = 1'b0;
      gnt_d        = 1'b0;
      ar_id_d      = ar_id_q;
      ar_addr_d    = ar_addr_q;
      ar_len_d     = ar_len_q;
      ar_size_d    = ar_size_q;
      ar_burst_d   = ar_burst_q;
      ar_lock_d    = ar_lock_q;
      ar_cache_d   = ar_cache_q;
      ar_prot_d    = ar_prot_q;
      ar_valid_d   = ar_valid_q;
      unique case (state_q)
         StIdle: begin
            if (elig_i && (!elig_d || last_grant_q)) begin
               gnt_i = 1'b1;
            end else if (elig_d) begin
               gnt_d = 1'b1;
            end
            if (gnt_i || gnt_d) begin
               ar_id_d      = gnt_d ? dcache_m_axi_arid_i    : icache_m_axi_arid_i;
               ar_id_d[0]   = gnt_d;
               ar_addr_d    = gnt_d ? dcache_m_axi_araddr_i  : icache_m_axi_araddr_i;
               ar_len_d     = gnt_d ? dcache_m_axi_arlen_i   : icache_m_axi_arlen_i;
               ar_size_d    = gnt_d ? dcache_m_axi_arsize_i  : icache_m_axi_arsize_i;
               ar_burst_d   = gnt_d ? dcache_m_axi_arburst_i : icache_m_axi_arburst_i;
               ar_lock_d    = gnt_d ? dcache_m_axi_arlock_i  : icache_m_axi_arlock_i;
               ar_cache_d   = gnt_d ? dcache_m_axi_arcache_i : icache_m_axi_arcache_i;
               ar_prot_d    = gnt_d ? dcache_m_axi_arprot_i  : icache_m_axi_arprot_i;
               ar_valid_d   = 1'b1;
               last_grant_d = gnt_d;
               state_d      = StBusy;
            end
         end
         StBusy: begin
            if (m_axi_arready_i) begin
               ar_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // R routing and outstanding-burst accounting
   assign r_tgt_d   = m_axi_rid_i[0];
   assign r_last_hs = m_axi_rvalid_i && m_axi_rready_o && m_axi_rlast_i;
   assign rlast_i   = r_last_hs && !r_tgt_d;
   assign rlast_d   = r_last_hs && r_tgt_d;
   assign dec_i     = rlast_i && (cnt_i_q != '0);
   assign dec_d     = rlast_d && (cnt_d_q != '0);

   always_comb begin
      cnt_i_d = cnt_i_q;
      cnt_d_d = cnt_d_q;
      unique case ({gnt_i, dec_i})
         2'b10:   cnt_i_d = cnt_i_q + 1'b1;
         2'b01:   cnt_i_d = cnt_i_q - 1'b1;
         default: cnt_i_d = cnt_i_q;
      endcase
      unique case ({gnt_d, dec_d})
         2'b10:   cnt_d_d = cnt_d_q + 1'b1;
         2'b01:   cnt_d_d = cnt_d_q - 1'b1;
         default: cnt_d_d = cnt_d_q;
      endcase
      rsp_err_d = rsp_err_q
                  || (rlast_i && (cnt_i_q == '0))
                  || (rlast_d && (cnt_d_q == '0));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         cnt_i_q      <= '0;
         cnt_d_q      <= '0;
         rsp_err_q    <= 1'b0;
         ar_id_q      <= '0;
         ar_addr_q    <= '0;
         ar_len_q     <= '0;
         ar_size_q    <= '0;
         ar_burst_q   <= '0;
         ar_lock_q    <= 1'b0;
         ar_cache_q   <= '0;
         ar_prot_q    <= '0;
         ar_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_i_q      <= cnt_i_d;
         cnt_d_q      <= cnt_d_d;
         rsp_err_q    <= rsp_err_d;
         ar_id_q      <= ar_id_d;
         ar_addr_q    <= ar_addr_d;
         ar_len_q     <= ar_len_d;
         ar_size_q    <= ar_size_d;
         ar_burst_q   <= ar_burst_d;
         ar_lock_q    <= ar_lock_d;
         ar_cache_q   <= ar_cache_d;
         ar_prot_q    <= ar_prot_d;
         ar_valid_q   <= ar_valid_d;
      end
   end

   assign icache_m_axi_arready_o = gnt_i;
   assign dcache_m_axi_arready_o = gnt_d;

   assign m_axi_arid_o    = ar_id_q;
   assign m_axi_araddr_o  = ar_addr_q;
   assign m_axi_arlen_o   = ar_len_q;
   assign m_axi_arsize_o  = ar_size_q;
   assign m_axi_arburst_o = ar_burst_q;
   assign m_axi_arlock_o  = ar_lock_q;
   assign m_axi_arcache_o = ar_cache_q;
   assign m_axi_arprot_o  = ar_prot_q;
   assign m_axi_arvalid_o = ar_valid_q;

   assign icache_m_axi_rid_o    = m_axi_rid_i;
   assign icache_m_axi_rdata_o  = m_axi_rdata_i;
   assign icache_m_axi_rresp_o  = m_axi_rresp_i;
   assign icache_m_axi_rlast_o  = m_axi_rlast_i;
   assign icache_m_axi_rvalid_o = m_axi_rvalid_i && !r_tgt_d;
   assign dcache_m_axi_rid_o    = m_axi_rid_i;
   assign dcache_m_axi_rdata_o  = m_axi_rdata_i;
   assign dcache_m_axi_rresp_o  = m_axi_rresp_i;
   assign dcache_m_axi_rlast_o  = m_axi_rlast_i;
   assign dcache_m_axi_rvalid_o = m_axi_rvalid_i && r_tgt_d;
   assign m_axi_rready_o        = r_tgt_d ? dcache_m_axi_rready_i : icache_m_axi_rready_i;

   assign rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grant, round-robin, throttling, R steering and errors.
module tb_axi_read_arbiter;

   localparam int unsigned IW = 13;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [IW-1:0] ic_arid, dc_arid, m_arid, ic_rid, dc_rid, m_rid;
   logic [AW-1:0] ic_araddr, dc_araddr, m_araddr;
   logic [7:0]    ic_arlen, dc_arlen, m_arlen;
   logic [2:0]    ic_arsize, dc_arsize, m_arsize, ic_arprot, dc_arprot, m_arprot;
   logic [1:0]    ic_arburst, dc_arburst, m_arburst, ic_rresp, dc_rresp, m_rresp;
   logic          ic_arlock, dc_arlock, m_arlock;
   logic [3:0]    ic_arcache, dc_arcache, m_arcache;
   logic          ic_arvalid, dc_arvalid, m_arvalid, ic_arready, dc_arready, m_arready;
   logic [DW-1:0] ic_rdata, dc_rdata, m_rdata;
   logic          ic_rlast, dc_rlast, m_rlast, ic_rvalid, dc_rvalid, m_rvalid;
   logic          ic_rready, dc_rready, m_rready, rsp_err;

   int vecs = 0;
   int errs = 0;

   axi_read_arbiter dut (
      .clk_i                  (clk),
      .reset_i                (reset),
      .icache_m_axi_arid_i    (ic_arid),
      .icache_m_axi_araddr_i  (ic_araddr),
      .icache_m_axi_arlen_i   (ic_arlen),
      .icache_m_axi_arsize_i  (ic_arsize),
      .icache_m_axi_arburst_i (ic_arburst),
      .icache_m_axi_arlock_i  (ic_arlock),
      .icache_m_axi_arcache_i (ic_arcache),
      .icache_m_axi_arprot_i  (ic_arprot),
      .icache_m_axi_arvalid_i (ic_arvalid),
      .icache_m_axi_arready_o (ic_arready),
      .icache_m_axi_rid_o     (ic_rid),
      .icache_m_axi_rdata_o   (ic_rdata),
      .icache_m_axi_rresp_o   (ic_rresp),
      .icache_m_axi_rlast_o   (ic_rlast),
      .icache_m_axi_rvalid_o  (ic_rvalid),
      .icache_m_axi_rready_i  (ic_rready),
      .dcache_m_axi_arid_i    (dc_arid),
      .dcache_m_axi_araddr_i  (dc_araddr),
      .dcache_m_axi_arlen_i   (dc_arlen),
      .dcache_m_axi_arsize_i  (dc_arsize),
      .dcache_m_axi_arburst_i (dc_arburst),
      .dcache_m_axi_arlock_i  (dc_arlock),
      .dcache_m_axi_arcache_i (dc_arcache),
      .dcache_m_axi_arprot_i  (dc_arprot),
      .dcache_m_axi_arvalid_i (dc_arvalid),
      .dcache_m_axi_arready_o (dc_arready),
      .dcache_m_axi_rid_o     (dc_rid),
      .dcache_m_axi_rdata_o   (dc_rdata),
      .dcache_m_axi_rresp_o   (dc_rresp),
      .dcache_m_axi_rlast_o   (dc_rlast),
      .dcache_m_axi_rvalid_o  (dc_rvalid),
      .dcache_m_axi_rready_i  (dc_rready),
      .m_axi_arid_o           (m_arid),
      .m_axi_araddr_o         (m_araddr),
      .m_axi_arlen_o          (m_arlen),
      .m_axi_arsize_o         (m_arsize),
      .m_axi_arburst_o        (m_arburst),
      .m_axi_arlock_o         (m_arlock),
      .m_axi_arcache_o        (m_arcache),
      .m_axi_arprot_o         (m_arprot),
      .m_axi_arvalid_o        (m_arvalid),
      .m_axi_arready_i        (m_arready),
      .m_axi_rid_i            (m_rid),
      .m_axi_rdata_i          (m_rdata),
      .m_axi_rresp_i          (m_rresp),
      .m_axi_rlast_i          (m_rlast),
      .m_axi_rvalid_i         (m_rvalid),
      .m_axi_rready_o         (m_rready),
      .rsp_err_o              (rsp_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ic_arid = '0; ic_araddr = '0; ic_arlen = '0; ic_arsize = '0; ic_arburst = '0;
      ic_arlock = 1'b0; ic_arcache = '0; ic_arprot = '0; ic_arvalid = 1'b0; ic_rready = 1'b0;
      dc_arid = '0; dc_araddr = '0; dc_arlen = '0; dc_arsize = '0; dc_arburst = '0;
      dc_arlock = 1'b0; dc_arcache = '0; dc_arprot = '0; dc_arvalid = 1'b0; dc_rready = 1'b0;
      m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
      repeat (2) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++; if (m_arvalid !== 1'b0) begin errs++; $display("FAIL rst_arvalid got %b exp 0", m_arvalid); end
      vecs++; if (m_araddr !== 64'h0 || m_arid !== 13'h0) begin
         errs++; $display("FAIL rst_payload got addr %h id %h exp 0 0", m_araddr, m_arid); end
      vecs++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL rst_err got %b exp 0", rsp_err); end
      vecs++; if (dut.cnt_i_q !== 3'd0 || dut.cnt_d_q !== 3'd0) begin
         errs++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", dut.cnt_i_q, dut.cnt_d_q); end
   endtask

   task automatic test_single();
      do_reset();
      ic_arvalid = 1'b1; ic_araddr = 64'h1000; ic_arid = 13'h2; ic_arlen = 8'd3;
      #1;
      vecs++; if (ic_arready !== 1'b1) begin errs++; $display("FAIL single_arready got %b exp 1", ic_arready); end
      step();
      ic_arvalid = 1'b0; ic_araddr = 64'hdead; ic_arid = 13'h1f;
      for (int k = 0; k < 3; k++) begin
         vecs++;
         if (m_arvalid !== 1'b1 || m_araddr !== 64'h1000 || m_arid !== 13'h2 || m_arlen !== 8'd3) begin
            errs++;
            $display("FAIL single_hold[%0d] got v%b a%h id%h len%0d exp v1 a1000 id2 len3",
                     k, m_arvalid, m_araddr, m_arid, m_arlen);
         end
         step();
      end
      m_arready = 1'b1;
      step();
      m_arready = 1'b0;
      vecs++; if (m_arvalid !== 1'b0) begin errs++; $display("FAIL single_drop got %b exp 0", m_arvalid); end
      vecs++; if (dut.cnt_i_q !== 3'd1) begin errs++; $display("FAIL single_cnt got %0d exp 1", dut.cnt_i_q); end
   endtask

   task automatic test_tie();
      do_reset();
      m_arready = 1'b1;
      ic_arvalid = 1'b1; ic_arid = 13'h2; ic_araddr = 64'h100;
      dc_arvalid = 1'b1; dc_arid = 13'h4; dc_araddr = 64'h200;
      #1;
      vecs++; if (ic_arready !== 1'b1 || dc_arready !== 1'b0) begin
         errs++; $display("FAIL tie1_grant got i%b d%b exp i1 d0", ic_arready, dc_arready); end
      step();
      vecs++; if (m_arid !== 13'h2 || m_araddr !== 64'h100) begin
         errs++; $display("FAIL tie1_ar got id %h addr %h exp 2 100", m_arid, m_araddr); end
      vecs++; if (ic_arready !== 1'b0 || dc_arready !== 1'b0) begin
         errs++; $display("FAIL tie_busy_rdy got i%b d%b exp 0 0", ic_arready, dc_arready); end
      step();
      vecs++; if (ic_arready !== 1'b0 || dc_arready !== 1'b1) begin
         errs++; $display("FAIL tie2_grant got i%b d%b exp i0 d1", ic_arready, dc_arready); end
      step();
      vecs++; if (m_arid !== 13'h5 || m_araddr !== 64'h200) begin
         errs++; $display("FAIL tie2_ar got id %h addr %h exp 5 200", m_arid, m_araddr); end
      step();
      vecs++; if (ic_arready !== 1'b1 || dc_arready !== 1'b0) begin
         errs++; $display("FAIL tie3_grant got i%b d%b exp i1 d0", ic_arready, dc_arready); end
      step();
      ic_arvalid = 1'b0; dc_arvalid = 1'b0;
      vecs++; if (m_arid !== 13'h2) begin errs++; $display("FAIL tie3_ar got id %h exp 2", m_arid); end
      step();
      m_arready = 1'b0;
   endtask

   task automatic test_throttle();
      do_reset();
      m_arready = 1'b1; ic_arvalid = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         vecs++; if (ic_arready !== 1'b1) begin errs++; $display("FAIL thr_grant[%0d] got %b exp 1", k, ic_arready); end
         step();
         step();
      end
      vecs++; if (dut.cnt_i_q !== 3'd4) begin errs++; $display("FAIL thr_cnt got %0d exp 4", dut.cnt_i_q); end
      dc_arvalid = 1'b1;
      #1;
      vecs++; if (ic_arready !== 1'b0 || dc_arready !== 1'b1) begin
         errs++; $display("FAIL thr_dgrant got i%b d%b exp i0 d1", ic_arready, dc_arready); end
      step();
      dc_arvalid = 1'b0;
      vecs++; if (m_arid[0] !== 1'b1) begin errs++; $display("FAIL thr_dtag got %b exp 1", m_arid[0]); end
      step();
      for (int k = 0; k < 3; k++) begin
         vecs++; if (ic_arready !== 1'b0) begin errs++; $display("FAIL thr_block[%0d] got %b exp 0", k, ic_arready); end
         step();
      end
      m_rvalid = 1'b1; m_rid = 13'h0; m_rlast = 1'b1; ic_rready = 1'b1;
      #1;
      vecs++; if (ic_rvalid !== 1'b1 || m_rready !== 1'b1) begin
         errs++; $display("FAIL thr_rbeat got rvalid %b rready %b exp 1 1", ic_rvalid, m_rready); end
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1;
      vecs++; if (ic_arready !== 1'b1) begin errs++; $display("FAIL thr_regrant got %b exp 1", ic_arready); end
      ic_arvalid = 1'b0;
      m_arready = 1'b0;
   endtask

   task automatic test_r_steer();
      logic [7:0] pat;
      logic [2:0] exp_cnt;
      int beat;
      do_reset();
      dc_arvalid = 1'b1;
      step();
      dc_arvalid = 1'b0; m_arready = 1'b1;
      step();
      m_arready = 1'b0;
      pat = 8'b1101_0101;  // bit c is dcache_rready in cycle c
      exp_cnt = 3'd1;
      beat = 0;
      ic_rready = 1'b1;
      for (int c = 0; c < 8 && beat < 4; c++) begin
         m_rvalid = 1'b1; m_rid = 13'h3; m_rdata = 64'hA0 + 64'(beat);
         m_rlast = (beat == 3); dc_rready = pat[c];
         #1;
         vecs++;
         if (ic_rvalid !== 1'b0 || dc_rvalid !== 1'b1 || m_rready !== pat[c]
             || ic_rdata !== 64'hA0 + 64'(beat) || dut.cnt_d_q !== exp_cnt) begin
            errs++;
            $display("FAIL steer[%0d] got iv%b dv%b rr%b data %h cnt %0d exp iv0 dv1 rr%b data %h cnt %0d",
                     c, ic_rvalid, dc_rvalid, m_rready, ic_rdata, dut.cnt_d_q, pat[c],
                     64'hA0 + 64'(beat), exp_cnt);
         end
         step();
         if (pat[c]) begin
            if (beat == 3) exp_cnt = 3'd0;
            beat++;
         end
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; dc_rready = 1'b0; ic_rready = 1'b0;
      vecs++; if (beat !== 4 || dut.cnt_d_q !== 3'd0 || rsp_err !== 1'b0) begin
         errs++; $display("FAIL steer_end got beats %0d cnt %0d err %b exp 4 0 0", beat, dut.cnt_d_q, rsp_err); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      m_arready = 1'b1; ic_arvalid = 1'b1;
      #1;
      repeat (4) step();
      vecs++; if (dut.cnt_i_q !== 3'd2) begin errs++; $display("FAIL sim_pre got %0d exp 2", dut.cnt_i_q); end
      m_rvalid = 1'b1; m_rid = 13'h0; m_rlast = 1'b1; ic_rready = 1'b1;
      #1;
      vecs++; if (ic_arready !== 1'b1) begin errs++; $display("FAIL sim_grant got %b exp 1", ic_arready); end
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0; ic_arvalid = 1'b0;
      vecs++; if (dut.cnt_i_q !== 3'd2) begin errs++; $display("FAIL sim_cnt got %0d exp 2", dut.cnt_i_q); end
      step();
      m_arready = 1'b0;
   endtask

   task automatic test_orphan_reset();
      do_reset();
      m_rvalid = 1'b1; m_rid = 13'h1; m_rlast = 1'b1; dc_rready = 1'b1;
      #1;
      vecs++; if (dc_rvalid !== 1'b1 || ic_rvalid !== 1'b0) begin
         errs++; $display("FAIL orph_route got d%b i%b exp d1 i0", dc_rvalid, ic_rvalid); end
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      vecs++; if (rsp_err !== 1'b1 || dut.cnt_d_q !== 3'd0) begin
         errs++; $display("FAIL orph_set got err %b cnt %0d exp 1 0", rsp_err, dut.cnt_d_q); end
      repeat (2) step();
      vecs++; if (rsp_err !== 1'b1) begin errs++; $display("FAIL orph_sticky got %b exp 1", rsp_err); end
      ic_arvalid = 1'b1; ic_araddr = 64'h40;
      step();
      ic_arvalid = 1'b0;
      vecs++; if (m_arvalid !== 1'b1) begin errs++; $display("FAIL rst_busy_pre got %b exp 1", m_arvalid); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      vecs++; if (m_arvalid !== 1'b0 || m_araddr !== 64'h0 || rsp_err !== 1'b0
                  || dut.cnt_i_q !== 3'd0 || dut.cnt_d_q !== 3'd0) begin
         errs++; $display("FAIL midrst got v%b a%h err%b cnt %0d/%0d exp 0 0 0 0/0",
                          m_arvalid, m_araddr, rsp_err, dut.cnt_i_q, dut.cnt_d_q); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_throttle();
      test_r_steer();
      test_simultaneous();
      test_orphan_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
